snitch_fpu_share_arbiter: RTL and testbench
===========================================

Name: snitch_fpu_share_arbiter

Overview:
- Shares one FPU instance (the snitch FPU wrapper: valid/ready in, valid/ready out, 8-bit tag) between NrReq requesters, e.g. cores of a cluster.
- Round-robin arbitration of issue requests; requester index is encoded into the upper FPU tag bits.
- Responses are routed back by tag.
- Per-requester outstanding-operation credit counters bound in-flight operations.

Parameters:
- NrReq, 2, number of requesters (2..4).
- DataWidth, 256, width of the opaque request payload (operands, rnd_mode, op, formats), passed through unmodified.
- FLEN, 64, FPU result width.
- MaxOutstanding, 4, maximum in-flight operations per requester (1..15).
- IdxWidth, derived = max(1, $clog2(NrReq)); ReqTagWidth, derived = 8 - IdxWidth.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  async active-low reset
- req_valid_i  in  NrReq  issue request valid per requester
- req_ready_o  out  NrReq  issue accepted
- req_data_i  in  NrReq x DataWidth  per-requester payload
- req_tag_i  in  NrReq x ReqTagWidth  per-requester tag
- fpu_valid_o  out  1  to FPU in_valid
- fpu_ready_i  in  1  from FPU in_ready
- fpu_data_o  out  DataWidth  granted payload
- fpu_tag_o  out  8  {grant index, requester tag}
- fpu_rsp_valid_i  in  1  FPU out_valid
- fpu_rsp_ready_o  out  1  FPU out_ready
- fpu_rsp_result_i  in  FLEN  FPU result
- fpu_rsp_status_i  in  5  FPU fflags
- fpu_rsp_tag_i  in  8  FPU tag
- rsp_valid_o  out  NrReq  one-hot response valid
- rsp_ready_i  in  NrReq  response ready per requester
- rsp_result_o  out  FLEN  broadcast result
- rsp_status_o  out  5  broadcast status
- rsp_tag_o  out  ReqTagWidth  lower tag bits
- idle_o  out  1  no in-flight operation and no pending request

Behaviour:
- Reset values: rr pointer=0, lock=0, all credit counters=0; consequently fpu_valid_o=0, req_ready_o=0, idle_o=1. rsp_valid_o follows fpu_rsp_valid_i combinationally, so it is 0 while the FPU is in reset.
- Eligibility: requester i is eligible if req_valid_i[i] and cnt[i] < MaxOutstanding.
- Arbitration: round-robin starting at the rr pointer, first eligible requester wins; zero-cycle combinational path from valid to fpu_valid_o.
- fpu_data_o/fpu_tag_o are the winner's payload and {i, req_tag_i[i]}.
- req_ready_o[i] = grant[i] & fpu_ready_i.
- Handshake on requester i: rr pointer <= (i+1) mod NrReq; cnt[i]++.
- Lock: if fpu_valid_o && !fpu_ready_i, the grant index is registered and held next cycle regardless of other requesters, until the handshake completes. Requesters must hold valid/data stable until ready. Lock clears on handshake.
- Response routing: idx = fpu_rsp_tag_i[7:8-IdxWidth].
  - In range: rsp_valid_o[idx] = fpu_rsp_valid_i; fpu_rsp_ready_o = rsp_ready_i[idx].
  - On response handshake: cnt[idx]--.
  - idx >= NrReq: response is consumed (ready=1) and dropped, no counter change.
- Simultaneous issue and response for the same requester: cnt unchanged.
- Counter at MaxOutstanding: requester is masked, others proceed; no overflow possible. Decrement at 0 (protocol violation): counter holds 0.
- Response backpressure stalls the FPU output only; issue continues independently.
- idle_o = all cnt==0 && no req_valid_i.
- Reset mid-operation clears counters and lock. The FPU shares the reset, so no stale responses remain.

Optional Feature:
- Macro: SNITCH_FPU_SHARE_PERF_EN.
- Defined: adds output stall_cnt_o (NrReq x 32). Each entry increments every cycle req_valid_i[i] && !req_ready_o[i], saturates at 2^32-1, and resets to 0.
- Undefined: port and counters absent, no logic.

Test Plan:
- Reset: rst_ni=0 with req_valid_i=2'b11 -> fpu_valid_o=0, req_ready_o=0, idle_o=1; after release, first grant goes to requester 0.
- Fairness: NrReq=2, both valid continuously, fpu_ready_i=1, MaxOutstanding=4, responses returned promptly -> grants alternate 0,1,0,1; fpu_tag_o[7]=index; counts each reach ≤1.
- Lock: requester 1 granted, fpu_ready_i=0 for 3 cycles while requester 0 becomes valid -> fpu_tag_o/data stay on requester 1 until ready, then requester 0 is granted.
- Credit limit: requester 0 issues 4 ops with no responses -> 5th request is held, req_ready_o[0]=0, while requester 1 is still granted; one response tagged 0x05 -> cnt[0]=3 and the next issue is accepted.
- Routing/backpressure: response tag 0x83 with rsp_ready_i=2'b01 -> rsp_valid_o=2'b10, fpu_rsp_ready_o=0 until rsp_ready_i[1]=1; rsp_tag_o=0x03. Simultaneous issue/response on requester 1 -> cnt[1] unchanged.
- Perf (macro defined): requester 1 blocked 7 cycles -> stall_cnt_o[1]=7, stall_cnt_o[0]=0.

Source files
------------

// File: rtl/snitch_fpu_share_arbiter.sv
// snitch_fpu_share_arbiter: shares one FPU between NrReq requesters.
// Issue requests are arbitrated round-robin, with a lock that holds a stalled
// grant. The requester index goes into the upper FPU tag bits, and responses
// are routed back by that index. Per-requester credit counters bound the
// number of in-flight operations.
// Optional feature: define SNITCH_FPU_SHARE_PERF_EN to add per-requester stall
// counters on stall_cnt_o.
module snitch_fpu_share_arbiter #(
    parameter int unsigned  NrReq          = 2,
    parameter int unsigned  DataWidth      = 256,
    parameter int unsigned  FLEN           = 64,
    parameter int unsigned  MaxOutstanding = 4,
    localparam int unsigned IdxWidth       = (NrReq > 1) ? $clog2(NrReq) : 1,
    localparam int unsigned ReqTagWidth    = 8 - IdxWidth
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic [NrReq-1:0]                      req_valid_i,
    output logic [NrReq-1:0]                      req_ready_o,
    input  logic [NrReq-1:0][DataWidth-1:0]       req_data_i,
    input  logic [NrReq-1:0][ReqTagWidth-1:0]     req_tag_i,
    output logic                                  fpu_valid_o,
    input  logic                                  fpu_ready_i,
    output logic [DataWidth-1:0]                  fpu_data_o,
    output logic [7:0]                            fpu_tag_o,
    input  logic                                  fpu_rsp_valid_i,
    output logic                                  fpu_rsp_ready_o,
    input  logic [FLEN-1:0]                       fpu_rsp_result_i,
    input  logic [4:0]                            fpu_rsp_status_i,
    input  logic [7:0]                            fpu_rsp_tag_i,
    output logic [NrReq-1:0]                      rsp_valid_o,
    input  logic [NrReq-1:0]                      rsp_ready_i,
    output logic [FLEN-1:0]                       rsp_result_o,
    output logic [4:0]                            rsp_status_o,
    output logic [ReqTagWidth-1:0]                rsp_tag_o,
    output logic                                  idle_o
`ifdef SNITCH_FPU_SHARE_PERF_EN
    ,
    output logic [NrReq-1:0][31:0]                stall_cnt_o
`endif
);

    localparam int unsigned CntWidth = $clog2(MaxOutstanding + 1);

    typedef logic [IdxWidth-1:0] idx_t;
    typedef logic [IdxWidth:0]   idx_ext_t;
    typedef logic [CntWidth-1:0] cnt_t;

    // While in reset, requests are ignored so that nothing is granted or
    // reported as pending.
    logic [NrReq-1:0] req_valid;
    logic [NrReq-1:0] eligible;
    logic [NrReq-1:0] cnt_zero;
    logic [NrReq-1:0] rsp_sel;

    idx_t rr_q, rr_d;
    idx_t lock_idx_q, lock_idx_d;
    logic lock_q, lock_d;

    idx_t win_idx;
    logic win_valid;
    logic issue_hs;

    idx_t rsp_idx;
    logic rsp_in_range;
    logic rsp_hs;

    assign req_valid = {NrReq{rst_ni}} & req_valid_i;

    // Pick the winner: the locked index, or the first eligible requester
    // going round-robin from the pointer. Lowest offset is visited last, so
    // it wins.
    always_comb begin
        idx_ext_t cand;
        cand      = '0;
        win_idx   = rr_q;
        win_valid = 1'b0;
        if (lock_q) begin
            win_idx   = lock_idx_q;
            win_valid = req_valid[lock_idx_q];
        end else begin
            for (int k = NrReq - 1; k >= 0; k--) begin
                cand = idx_ext_t'(rr_q) + idx_ext_t'(k);
                if (cand >= idx_ext_t'(NrReq)) begin
                    cand = cand - idx_ext_t'(NrReq);
                end
                if (eligible[idx_t'(cand)]) begin
                    win_idx   = idx_t'(cand);
                    win_valid = 1'b1;
                end
            end
        end
    end

    assign fpu_valid_o = win_valid;
    assign fpu_data_o  = req_data_i[win_idx];
    assign fpu_tag_o   = {win_idx, req_tag_i[win_idx]};
    assign issue_hs    = win_valid & fpu_ready_i;

    // Pointer advances past the winner on handshake; a stalled grant is locked.
    always_comb begin
        rr_d       = rr_q;
        lock_d     = fpu_valid_o & ~fpu_ready_i;
        lock_idx_d = win_idx;
        if (issue_hs) begin
            rr_d = (win_idx == idx_t'(NrReq - 1)) ? '0 : win_idx + idx_t'(1);
        end
    end

    // Arbitration state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q       <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
        end else begin
            rr_q       <= rr_d;
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
        end
    end

    // Response routing. An index that names no requester is consumed and dropped.
    assign rsp_idx         = fpu_rsp_tag_i[7 -: IdxWidth];
    assign rsp_in_range    = idx_ext_t'(rsp_idx) < idx_ext_t'(NrReq);
    assign fpu_rsp_ready_o = ~rsp_in_range | (|(rsp_sel & rsp_ready_i));
    assign rsp_hs          = fpu_rsp_valid_i & fpu_rsp_ready_o;
    assign rsp_result_o    = fpu_rsp_result_i;
    assign rsp_status_o    = fpu_rsp_status_i;
    assign rsp_tag_o       = fpu_rsp_tag_i[ReqTagWidth-1:0];

    assign idle_o = (&cnt_zero) & ~(|req_valid);

    for (genvar gi = 0; gi < NrReq; gi++) begin : gen_req
        cnt_t cnt_q, cnt_d;
        logic inc, dec;

        assign eligible[gi]    = req_valid[gi] & (cnt_q < cnt_t'(MaxOutstanding));
        assign req_ready_o[gi] = issue_hs & (win_idx == idx_t'(gi));
        assign rsp_sel[gi]     = rsp_in_range & (rsp_idx == idx_t'(gi));
        assign rsp_valid_o[gi] = fpu_rsp_valid_i & rsp_sel[gi];
        assign cnt_zero[gi]    = (cnt_q == '0);
        assign inc             = req_ready_o[gi];
        assign dec             = rsp_hs & rsp_sel[gi];

        // Credit update. Issue and response together cancel out, and a
        // stray response at zero leaves the counter at zero.
        always_comb begin
            cnt_d = cnt_q;
            if (inc && !dec) begin
                cnt_d = cnt_q + cnt_t'(1);
            end else if (dec && !inc && cnt_q != '0) begin
                cnt_d = cnt_q - cnt_t'(1);
            end
        end

        // Credit counter register.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

`ifdef SNITCH_FPU_SHARE_PERF_EN
        logic [31:0] stall_q, stall_d;

        // Count cycles where this requester waits, saturating at all-ones.
        always_comb begin
            stall_d = stall_q;
            if (req_valid[gi] && !req_ready_o[gi] && stall_q != '1) begin
                stall_d = stall_q + 32'd1;
            end
        end

        // Stall counter register.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                stall_q <= '0;
            end else begin
                stall_q <= stall_d;
            end
        end

        assign stall_cnt_o[gi] = stall_q;
`endif
    end

endmodule

// File: tb/tb_snitch_fpu_share_arbiter.sv
// Directed testbench for snitch_fpu_share_arbiter (NrReq=2, MaxOutstanding=4).
module tb_snitch_fpu_share_arbiter;

    localparam int unsigned NR = 2;
    localparam int unsigned DW = 32;
    localparam int unsigned FL = 64;
    localparam int unsigned MO = 4;

    logic                    clk_i = 1'b0;
    logic                    rst_ni = 1'b0;
    logic [NR-1:0]           req_valid_i;
    logic [NR-1:0]           req_ready_o;
    logic [NR-1:0][DW-1:0]   req_data_i;
    logic [NR-1:0][6:0]      req_tag_i;
    logic                    fpu_valid_o;
    logic                    fpu_ready_i;
    logic [DW-1:0]           fpu_data_o;
    logic [7:0]              fpu_tag_o;
    logic                    fpu_rsp_valid_i;
    logic                    fpu_rsp_ready_o;
    logic [FL-1:0]           fpu_rsp_result_i;
    logic [4:0]              fpu_rsp_status_i;
    logic [7:0]              fpu_rsp_tag_i;
    logic [NR-1:0]           rsp_valid_o;
    logic [NR-1:0]           rsp_ready_i;
    logic [FL-1:0]           rsp_result_o;
    logic [4:0]              rsp_status_o;
    logic [6:0]              rsp_tag_o;
    logic                    idle_o;
`ifdef SNITCH_FPU_SHARE_PERF_EN
    logic [NR-1:0][31:0]     stall_cnt_o;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk_i = ~clk_i;

    snitch_fpu_share_arbiter #(
        .NrReq          (NR),
        .DataWidth      (DW),
        .FLEN           (FL),
        .MaxOutstanding (MO)
    ) dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .req_valid_i      (req_valid_i),
        .req_ready_o      (req_ready_o),
        .req_data_i       (req_data_i),
        .req_tag_i        (req_tag_i),
        .fpu_valid_o      (fpu_valid_o),
        .fpu_ready_i      (fpu_ready_i),
        .fpu_data_o       (fpu_data_o),
        .fpu_tag_o        (fpu_tag_o),
        .fpu_rsp_valid_i  (fpu_rsp_valid_i),
        .fpu_rsp_ready_o  (fpu_rsp_ready_o),
        .fpu_rsp_result_i (fpu_rsp_result_i),
        .fpu_rsp_status_i (fpu_rsp_status_i),
        .fpu_rsp_tag_i    (fpu_rsp_tag_i),
        .rsp_valid_o      (rsp_valid_o),
        .rsp_ready_i      (rsp_ready_i),
        .rsp_result_o     (rsp_result_o),
        .rsp_status_o     (rsp_status_o),
        .rsp_tag_o        (rsp_tag_o),
        .idle_o           (idle_o)
`ifdef SNITCH_FPU_SHARE_PERF_EN
        ,
        .stall_cnt_o      (stall_cnt_o)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    // Advance one clock; inputs change 1 time unit after the edge.
    task automatic cyc;
        @(posedge clk_i);
        #1;
    endtask

    // Let combinational outputs settle before sampling.
    task automatic settle;
        #1;
    endtask

    initial begin
        logic [7:0] exp_tag;
        req_valid_i      = '0;
        req_data_i[0]    = 32'hA0A0_0000;
        req_data_i[1]    = 32'hB1B1_0001;
        req_tag_i[0]     = 7'h11;
        req_tag_i[1]     = 7'h22;
        fpu_ready_i      = 1'b1;
        fpu_rsp_valid_i  = 1'b0;
        fpu_rsp_result_i = 64'hDEAD_BEEF_0123_4567;
        fpu_rsp_status_i = 5'h0A;
        fpu_rsp_tag_i    = 8'h00;
        rsp_ready_i      = 2'b11;

        // Reset with both requesters asking.
        rst_ni      = 1'b0;
        req_valid_i = 2'b11;
        repeat (2) @(posedge clk_i);
        #2;
        check("rst_fpu_valid", 64'(fpu_valid_o), 64'(1'b0));
        check("rst_req_ready", 64'(req_ready_o), 64'(2'b00));
        check("rst_idle", 64'(idle_o), 64'(1'b1));
        rst_ni = 1'b1;
        settle;
        check("first_grant_tag", 64'(fpu_tag_o), 64'(8'h11));
        check("first_grant_ready", 64'(req_ready_o), 64'(2'b01));
        check("first_grant_data", 64'(fpu_data_o), 64'(32'hA0A0_0000));
        cyc;

        // Fairness: alternate grants while the previous op's response returns.
        for (int k = 1; k <= 3; k++) begin
            fpu_rsp_valid_i = 1'b1;
            fpu_rsp_tag_i   = (k % 2 == 1) ? 8'h00 : 8'h80;
            settle;
            exp_tag = (k % 2 == 1) ? 8'hA2 : 8'h11;
            check("rr_tag", 64'(fpu_tag_o), 64'(exp_tag));
            check("rr_ready", 64'(req_ready_o), (k % 2 == 1) ? 64'(2'b10) : 64'(2'b01));
            check("rr_rsp_valid", 64'(rsp_valid_o), (k % 2 == 1) ? 64'(2'b01) : 64'(2'b10));
            cyc;
        end
        req_valid_i   = 2'b00;
        fpu_rsp_tag_i = 8'h80;
        settle;
        check("rr_idle_busy", 64'(idle_o), 64'(1'b0));
        cyc;
        fpu_rsp_valid_i = 1'b0;
        settle;
        check("rr_idle_done", 64'(idle_o), 64'(1'b1));

        // Lock: requester 1 stalls for 3 cycles while requester 0 joins.
        req_valid_i = 2'b10;
        fpu_ready_i = 1'b0;
        settle;
        check("lock_valid", 64'(fpu_valid_o), 64'(1'b1));
        check("lock_tag0", 64'(fpu_tag_o), 64'(8'hA2));
        check("lock_ready0", 64'(req_ready_o), 64'(2'b00));
        cyc;
        req_valid_i = 2'b11;
        for (int k = 0; k < 2; k++) begin
            settle;
            check("lock_tag_held", 64'(fpu_tag_o), 64'(8'hA2));
            check("lock_data_held", 64'(fpu_data_o), 64'(32'hB1B1_0001));
            check("lock_ready_held", 64'(req_ready_o), 64'(2'b00));
            cyc;
        end
        fpu_ready_i = 1'b1;
        settle;
        check("lock_release_tag", 64'(fpu_tag_o), 64'(8'hA2));
        check("lock_release_ready", 64'(req_ready_o), 64'(2'b10));
        cyc;
        req_valid_i = 2'b01;
        settle;
        check("after_lock_tag", 64'(fpu_tag_o), 64'(8'h11));
        check("after_lock_ready", 64'(req_ready_o), 64'(2'b01));
        cyc;
        req_valid_i     = 2'b00;
        fpu_rsp_valid_i = 1'b1;
        fpu_rsp_tag_i   = 8'h80;
        settle;
        check("drain_rsp_ready", 64'(fpu_rsp_ready_o), 64'(1'b1));
        cyc;
        fpu_rsp_tag_i = 8'h00;
        cyc;
        fpu_rsp_valid_i = 1'b0;
        settle;
        check("lock_idle", 64'(idle_o), 64'(1'b1));

        // Credit limit: requester 0 fills its 4 credits.
        req_valid_i = 2'b01;
        for (int k = 0; k < 4; k++) begin
            settle;
            check("credit_fill_ready", 64'(req_ready_o), 64'(2'b01));
            cyc;
        end
        settle;
        check("credit_full_valid", 64'(fpu_valid_o), 64'(1'b0));
        check("credit_full_ready", 64'(req_ready_o), 64'(2'b00));
        req_valid_i = 2'b11;
        settle;
        check("credit_other_ready", 64'(req_ready_o), 64'(2'b10));
        cyc;
        settle;
        check("credit_masked_ready", 64'(req_ready_o), 64'(2'b10));
        cyc;
        req_valid_i     = 2'b01;
        fpu_rsp_valid_i = 1'b1;
        fpu_rsp_tag_i   = 8'h05;
        settle;
        check("credit_rsp_ready", 64'(req_ready_o), 64'(2'b00));
        check("credit_rsp_valid", 64'(rsp_valid_o), 64'(2'b01));
        check("credit_rsp_tag", 64'(rsp_tag_o), 64'(7'h05));
        cyc;
        fpu_rsp_valid_i = 1'b0;
        settle;
        check("credit_reissue", 64'(req_ready_o), 64'(2'b01));
        cyc;
        settle;
        check("credit_full_again", 64'(req_ready_o), 64'(2'b00));
        req_valid_i     = 2'b00;
        fpu_rsp_valid_i = 1'b1;
        for (int k = 0; k < 6; k++) begin
            fpu_rsp_tag_i = (k < 4) ? 8'h00 : 8'h80;
            cyc;
        end
        fpu_rsp_valid_i = 1'b0;
        settle;
        check("credit_idle", 64'(idle_o), 64'(1'b1));

        // Routing and backpressure on requester 1.
        req_valid_i = 2'b10;
        settle;
        check("route_issue", 64'(req_ready_o), 64'(2'b10));
        cyc;
        req_valid_i     = 2'b00;
        fpu_rsp_valid_i = 1'b1;
        fpu_rsp_tag_i   = 8'h83;
        rsp_ready_i     = 2'b01;
        settle;
        check("route_rsp_valid", 64'(rsp_valid_o), 64'(2'b10));
        check("route_bp_ready", 64'(fpu_rsp_ready_o), 64'(1'b0));
        check("route_rsp_tag", 64'(rsp_tag_o), 64'(7'h03));
        check("route_result", rsp_result_o, 64'hDEAD_BEEF_0123_4567);
        check("route_status", 64'(rsp_status_o), 64'(5'h0A));
        cyc;
        req_valid_i = 2'b01;
        settle;
        check("route_bp_held", 64'(fpu_rsp_ready_o), 64'(1'b0));
        check("route_bp_valid", 64'(rsp_valid_o), 64'(2'b10));
        check("route_issue_indep", 64'(req_ready_o), 64'(2'b01));
        cyc;
        rsp_ready_i = 2'b11;
        req_valid_i = 2'b10;
        settle;
        check("route_rsp_accept", 64'(fpu_rsp_ready_o), 64'(1'b1));
        check("route_simul_issue", 64'(req_ready_o), 64'(2'b10));
        cyc;
        req_valid_i   = 2'b00;
        fpu_rsp_tag_i = 8'h00;
        cyc;
        fpu_rsp_valid_i = 1'b0;
        settle;
        check("simul_cnt1_held", 64'(idle_o), 64'(1'b0));
        fpu_rsp_valid_i = 1'b1;
        fpu_rsp_tag_i   = 8'h80;
        cyc;
        fpu_rsp_valid_i = 1'b0;
        settle;
        check("route_idle", 64'(idle_o), 64'(1'b1));

        // Reset in the middle of an outstanding operation.
        req_valid_i = 2'b01;
        cyc;
        req_valid_i = 2'b00;
        settle;
        check("midrst_busy", 64'(idle_o), 64'(1'b0));
        rst_ni = 1'b0;
        settle;
        rst_ni = 1'b1;
        settle;
        check("midrst_idle", 64'(idle_o), 64'(1'b1));

`ifdef SNITCH_FPU_SHARE_PERF_EN
        // Stall counters: requester 1 blocked for 7 cycles.
        rst_ni = 1'b0;
        settle;
        rst_ni = 1'b1;
        settle;
        check("perf_rst1", 64'(stall_cnt_o[1]), 64'd0);
        req_valid_i = 2'b10;
        fpu_ready_i = 1'b0;
        repeat (7) cyc;
        check("perf_stall1", 64'(stall_cnt_o[1]), 64'd7);
        check("perf_stall0", 64'(stall_cnt_o[0]), 64'd0);
        fpu_ready_i = 1'b1;
        cyc;
        req_valid_i = 2'b00;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
